// File: rtl/pingpong_pkg.sv
// Shared constants and types for the ping-pong game blocks (paddle, ball, render).
package pingpong_pkg;

   localparam int unsigned SCREEN_H   = 480;
   localparam int unsigned PAT_H      = 64;
   localparam int unsigned PAT_INIT_Y = 208;
   localparam int unsigned PAT_Y_MAX  = SCREEN_H - PAT_H;

   localparam int unsigned TILT_W = 8;
   localparam int unsigned POS_W  = 10;

   typedef logic signed [TILT_W-1:0] tilt_t;

endpackage

// File: rtl/tilt_averager.sv
// Four-deep tilt sample history with a combinational floor-average of the held entries.
module tilt_averager
   import pingpong_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  i_clear,
   input  logic  i_sample_valid,
   input  tilt_t i_sample_data,
   output tilt_t o_avg_c
);

   localparam int unsigned DEPTH = 4;
   localparam int unsigned SUM_W = 10;
   localparam int unsigned CNT_W = 3;

   tilt_t                   r_hist [DEPTH];
   logic [CNT_W-1:0]        r_hist_cnt;
   logic signed [SUM_W-1:0] w_sum;

   // Shift in new samples (newest at index 0); clear wins over a same-cycle sample.
   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
         r_hist_cnt <= '0;
      end else if (i_sample_valid) begin
         r_hist[0] <= i_sample_data;
         for (int i = 1; i < DEPTH; i++) r_hist[i] <= r_hist[i-1];
         if (r_hist_cnt != CNT_W'(DEPTH)) r_hist_cnt <= r_hist_cnt + CNT_W'(1);
      end
   end

   // Sign-extended sum of the valid entries; entries not yet filled contribute zero.
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < r_hist_cnt)
            w_sum = w_sum + {{(SUM_W-TILT_W){r_hist[i][TILT_W-1]}}, r_hist[i]};
      end
   end

   // Dropping the two LSBs of the signed sum is an arithmetic divide by 4 toward -inf.
   assign o_avg_c = w_sum[SUM_W-1:2];

endmodule

// File: rtl/pat_datapath.sv
// Paddle datapath: latches averaged tilt on fetch, steps and clamps the paddle on update.
module pat_datapath
   import pingpong_pkg::*;
#(
   parameter int unsigned STEP_SHIFT = 2,
   parameter int unsigned DEADZONE   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              initial_pat,
   input  logic              fetch,
   input  logic              update_pat,
   input  logic              halt,
   input  logic              sample_valid,
   input  logic [TILT_W-1:0] sample_data,
   output logic [POS_W-1:0]  pat_y,
   output logic [POS_W-1:0]  pat_bottom,
   output logic              moved,
   output logic [TILT_W-1:0] tilt_avg
);

   localparam int unsigned NEXT_W = POS_W + 1;
   localparam int unsigned MAG_W  = TILT_W + 1;
   localparam logic signed [NEXT_W-1:0] Y_MAX_S = NEXT_W'(PAT_Y_MAX);

   tilt_t                    w_avg;
   tilt_t                    r_tilt_avg;
   logic [POS_W-1:0]         r_pat_y;
   logic [POS_W-1:0]         r_pat_bottom;
   logic                     r_moved;
   logic signed [MAG_W-1:0]  w_avg_ext;
   logic [MAG_W-1:0]         w_mag;
   tilt_t                    w_step;
   logic signed [NEXT_W-1:0] w_next;
   logic [POS_W-1:0]         w_clamped;

   tilt_averager u_avg (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_clear        (initial_pat),
      .i_sample_valid (sample_valid),
      .i_sample_data  (tilt_t'(sample_data)),
      .o_avg_c        (w_avg)
   );

   // Dead-zone test on |tilt_avg|; 9 bits so that |-128| is representable.
   always_comb begin
      w_avg_ext = {r_tilt_avg[TILT_W-1], r_tilt_avg};
      w_mag     = w_avg_ext[MAG_W-1] ? MAG_W'(-w_avg_ext) : MAG_W'(w_avg_ext);
      w_step    = (w_mag <= MAG_W'(DEADZONE)) ? tilt_t'(0) : tilt_t'(r_tilt_avg >>> STEP_SHIFT);
   end

   // Signed next position, clamped to the visible paddle range.
   always_comb begin
      w_next = $signed({1'b0, r_pat_y}) + {{(NEXT_W-TILT_W){w_step[TILT_W-1]}}, w_step};
      if (w_next < 0)
         w_clamped = '0;
      else if (w_next > Y_MAX_S)
         w_clamped = POS_W'(PAT_Y_MAX);
      else
         w_clamped = w_next[POS_W-1:0];
   end

   // Position/average registers; priority initial_pat > halt > update_pat > fetch.
   always_ff @(posedge clk) begin
      if (!rst_n || initial_pat) begin
         r_pat_y      <= POS_W'(PAT_INIT_Y);
         r_pat_bottom <= POS_W'(PAT_INIT_Y + PAT_H - 1);
         r_moved      <= 1'b0;
         r_tilt_avg   <= '0;
      end else begin
         r_moved <= 1'b0;
         if (!halt) begin
            if (update_pat) begin
               r_pat_y      <= w_clamped;
               r_pat_bottom <= w_clamped + POS_W'(PAT_H - 1);
               r_moved      <= (w_clamped != r_pat_y);
            end else if (fetch) begin
               r_tilt_avg <= w_avg;
            end
         end
      end
   end

   assign pat_y      = r_pat_y;
   assign pat_bottom = r_pat_bottom;
   assign moved      = r_moved;
   assign tilt_avg   = r_tilt_avg;

endmodule
